mem_arbiter: RTL and testbench

Shares one single-port unified memory between the core's instruction-fetch port and its data-memory port. Sits between the pipelined core's IMEM/DMEM interfaces and the memory. Grants one requester at a time and holds the memory handshake until it is acknowledged. Returns read data with a one-cycle valid pulse and drives a stall line to the hazard unit while any request is outstanding.

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data access; define MEM_ARB_TIMEOUT_EN for bus timeout abort with sticky err_o
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IMEM_addr_i,
  input  logic        IMEM_read_n_i,
  output logic [31:0] IMEM_data_o,
  output logic        IMEM_valid_o,
  input  logic        DMEM_read_i,
  input  logic        DMEM_write_i,
  input  logic [31:0] DMEM_addr_i,
  input  logic [31:0] DMEM_data_i,
  output logic [31:0] DMEM_data_o,
  output logic        DMEM_valid_o,
  output logic        MEM_req_o,
  output logic        MEM_we_o,
  output logic [31:0] MEM_addr_o,
  output logic [31:0] MEM_wdata_o,
  input  logic [31:0] MEM_rdata_i,
  input  logic        MEM_ack_i,
  output logic        stall_o,
  output logic        err_o
);
  typedef enum logic [1:0] {IDLE, IBUS, DBUS} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] imem_data_q, imem_data_d, dmem_data_q, dmem_data_d;
  logic        imem_valid_q, imem_valid_d, dmem_valid_q, dmem_valid_d;
  logic [3:0]  starve_q, starve_d;
  logic        fetch_pend, data_pend, grant_i, grant_d, done, abort;
  logic [31:0] rdata;
  assign fetch_pend = ~IMEM_read_n_i;
  assign data_pend  = DMEM_read_i | DMEM_write_i;
  assign grant_i    = (state_q == IDLE) && fetch_pend && (!data_pend || starve_q == LIM);
  assign grant_d    = (state_q == IDLE) && data_pend && !grant_i;
  assign done       = (state_q != IDLE) && MEM_ack_i;
  assign rdata      = abort ? 32'h0 : MEM_rdata_i;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  assign abort = (state_q != IDLE) && !MEM_ack_i && tmo_q == TW'(TIMEOUT - 1);
  assign err_o = err_q;
  // bus-cycle counter restarts every grant; the error flag sticks until reset
  always_comb begin
    tmo_d = (state_q == IDLE) ? '0 : tmo_q + 1'b1;
    err_d = err_q | abort;
  end
  // timeout state register
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif
  assign stall_o      = (fetch_pend & ~imem_valid_q) | (data_pend & ~dmem_valid_q);
  assign MEM_req_o    = mem_req_q;
  assign MEM_we_o     = mem_we_q;
  assign MEM_addr_o   = mem_addr_q;
  assign MEM_wdata_o  = mem_wdata_q;
  assign IMEM_data_o  = imem_data_q;
  assign IMEM_valid_o = imem_valid_q;
  assign DMEM_data_o  = dmem_data_q;
  assign DMEM_valid_o = dmem_valid_q;
  // arbitration, bus handshake hold, completion pulses and starvation count
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    imem_data_d  = imem_data_q;
    dmem_data_d  = dmem_data_q;
    imem_valid_d = 1'b0;
    dmem_valid_d = 1'b0;
    starve_d     = !fetch_pend || grant_i ? 4'd0 :
                   grant_d && starve_q != LIM ? starve_q + 4'd1 : starve_q;
    if (grant_i) begin
      state_d    = IBUS;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = IMEM_addr_i;
    end else if (grant_d) begin
      state_d     = DBUS;
      mem_req_d   = 1'b1;
      mem_we_d    = DMEM_write_i;
      mem_addr_d  = DMEM_addr_i;
      mem_wdata_d = DMEM_data_i;
    end else if (done || abort) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      if (state_q == IBUS) begin
        imem_valid_d = 1'b1;
        imem_data_d  = rdata;
      end else begin
        dmem_valid_d = 1'b1;
        dmem_data_d  = (!mem_we_q || abort) ? rdata : dmem_data_q;
      end
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      imem_data_q  <= '0;
      dmem_data_q  <= '0;
      imem_valid_q <= 1'b0;
      dmem_valid_q <= 1'b0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      imem_data_q  <= imem_data_d;
      dmem_data_q  <= dmem_data_d;
      imem_valid_q <= imem_valid_d;
      dmem_valid_q <= dmem_valid_d;
      starve_q     <= starve_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and memory against a transaction-level arbitration model
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  logic        clk = 1'b0, reset;
  logic [31:0] IMEM_addr_i, IMEM_data_o, DMEM_addr_i, DMEM_data_i, DMEM_data_o;
  logic [31:0] MEM_addr_o, MEM_wdata_o, MEM_rdata_i;
  logic        IMEM_read_n_i, IMEM_valid_o, DMEM_read_i, DMEM_write_i, DMEM_valid_o;
  logic        MEM_req_o, MEM_we_o, MEM_ack_i, stall_o, err_o;
  mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .IMEM_addr_i(IMEM_addr_i), .IMEM_read_n_i(IMEM_read_n_i), .IMEM_data_o(IMEM_data_o), .IMEM_valid_o(IMEM_valid_o),
    .DMEM_read_i(DMEM_read_i), .DMEM_write_i(DMEM_write_i), .DMEM_addr_i(DMEM_addr_i), .DMEM_data_i(DMEM_data_i),
    .DMEM_data_o(DMEM_data_o), .DMEM_valid_o(DMEM_valid_o),
    .MEM_req_o(MEM_req_o), .MEM_we_o(MEM_we_o), .MEM_addr_o(MEM_addr_o), .MEM_wdata_o(MEM_wdata_o),
    .MEM_rdata_i(MEM_rdata_i), .MEM_ack_i(MEM_ack_i), .stall_o(stall_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask
  int          busy, starve, wait_cnt, forced, p_i, p_d, r;
  logic        bwe, exp_iv, exp_dv, exp_stall, fp, dp;
  logic [31:0] baddr, bwdata, exp_idata, exp_ddata;
  initial begin
    reset = 1'b1;
    IMEM_read_n_i = 1'b1; IMEM_addr_i = '0;
    DMEM_read_i = 1'b0; DMEM_write_i = 1'b0; DMEM_addr_i = '0; DMEM_data_i = '0;
    MEM_ack_i = 1'b0; MEM_rdata_i = '0;
    busy = 0; starve = 0; wait_cnt = 0; forced = 0;
    bwe = 1'b0; baddr = '0; bwdata = '0;
    exp_iv = 1'b0; exp_dv = 1'b0; exp_idata = '0; exp_ddata = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      case (cyc / 1000)
        0:       begin p_i = 100; p_d = 100; end
        1:       begin p_i = 30;  p_d = 30;  end
        2:       begin p_i = 80;  p_d = 20;  end
        default: begin p_i = 10;  p_d = 90;  end
      endcase
      exp_stall = (!IMEM_read_n_i && !exp_iv) || ((DMEM_read_i || DMEM_write_i) && !exp_dv);
      chk("mem_req", MEM_req_o, busy != 0);
      if (busy != 0) begin
        chk("mem_addr", MEM_addr_o, baddr);
        chk("mem_we", MEM_we_o, bwe);
        if (bwe) chk("mem_wdata", MEM_wdata_o, bwdata);
      end
      chk("imem_valid", IMEM_valid_o, exp_iv);
      chk("dmem_valid", DMEM_valid_o, exp_dv);
      chk("imem_data", IMEM_data_o, exp_idata);
      chk("dmem_data", DMEM_data_o, exp_ddata);
      chk("stall", stall_o, exp_stall);
      chk("err", err_o, 1'b0);
      reset = (cyc < 2) || (busy != 0 && $urandom_range(0, 199) == 0);
      if (exp_iv) IMEM_read_n_i = 1'b1;
      if (exp_dv) begin DMEM_read_i = 1'b0; DMEM_write_i = 1'b0; end
      if (busy == 1 && $urandom_range(0, 49) == 0) IMEM_read_n_i = 1'b1;
      if (busy == 2 && $urandom_range(0, 49) == 0) begin DMEM_read_i = 1'b0; DMEM_write_i = 1'b0; end
      if (!reset && IMEM_read_n_i && busy != 1 && $urandom_range(0, 99) < p_i) begin
        IMEM_read_n_i = 1'b0;
        IMEM_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!reset && !DMEM_read_i && !DMEM_write_i && busy != 2 && $urandom_range(0, 99) < p_d) begin
        r = $urandom_range(0, 9);
        DMEM_read_i  = (r < 4) || (r >= 8);
        DMEM_write_i = (r >= 4);
        DMEM_addr_i = $urandom & 32'hFFFF_FFFC;
        DMEM_data_i = $urandom;
      end
      MEM_rdata_i = $urandom;
      if (busy != 0) begin
        MEM_ack_i = (wait_cnt == 0);
        if (wait_cnt != 0) wait_cnt--;
      end else MEM_ack_i = ($urandom_range(0, 7) == 0);
      fp = !IMEM_read_n_i;
      dp = DMEM_read_i || DMEM_write_i;
      exp_iv = 1'b0;
      exp_dv = 1'b0;
      if (reset) begin
        busy = 0; starve = 0; bwe = 1'b0; baddr = '0; bwdata = '0;
        exp_idata = '0; exp_ddata = '0;
      end else if (busy != 0) begin
        if (MEM_ack_i) begin
          if (busy == 1) begin exp_iv = 1'b1; exp_idata = MEM_rdata_i; end
          else begin exp_dv = 1'b1; if (!bwe) exp_ddata = MEM_rdata_i; end
          busy = 0;
        end
        if (!fp) starve = 0;
      end else if (dp && !(fp && starve == LIMIT)) begin
        busy = 2; bwe = DMEM_write_i; baddr = DMEM_addr_i; bwdata = DMEM_data_i;
        starve = fp ? (starve == LIMIT ? LIMIT : starve + 1) : 0;
        wait_cnt = $urandom_range(0, 3);
      end else if (fp) begin
        if (dp) forced++;
        busy = 1; bwe = 1'b0; baddr = IMEM_addr_i;
        starve = 0;
        wait_cnt = $urandom_range(0, 3);
      end else starve = 0;
    end
    $display("forced fetch grants: %0d", forced);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
